clock_enable_gen: RTL and testbench



---
 rtl/clock_enable_gen.sv | 147 ++++++++++++++
 tb/tb_clock_enable_gen.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_gen.sv
// rtl/clock_enable_gen.sv - PLL lock sequencer with fractional-rate clock-enable channels
//
// Holds the system in reset until the PLL lock has been stable for
// LOCK_CYCLES clocks, then releases it and runs NUM_CH phase accumulators
// that emit one-cycle clock-enable pulses at an average rate of
// f_clk * INC_i / 2^ACC_W.
//
// Ports:
//   clk        in   PLL output clock
//   rst        in   asynchronous active-high reset
//   pll_lock   in   PLL lock, asynchronous to clk
//   ch_en      in   per-channel run enable [NUM_CH]
//   phase_sync in   zeroes all accumulators on the edge it is sampled high
//   sys_rst    out  system reset, asserts asynchronously, releases on clk
//   ready      out  high while running
//   ce         out  registered one-cycle enable pulses [NUM_CH]
//   lock_lost  out  sticky: lock dropped while running, cleared only by rst

module clock_enable_gen #(
    parameter int                       NUM_CH      = 2,
    parameter int                       ACC_W       = 16,
    parameter logic [NUM_CH*ACC_W-1:0]  INC         = {16'd1311, 16'd32768},
    parameter int                       LOCK_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_lock,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              phase_sync,
    output logic              sys_rst,
    output logic              ready,
    output logic [NUM_CH-1:0] ce,
    output logic              lock_lost
);

    localparam int              CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        COUNT     = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           sync1_q, sync2_q;
    logic [NUM_CH-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [NUM_CH-1:0]              ce_q, ce_d;
    logic                           lock_lost_q, lock_lost_d;
    logic [NUM_CH-1:0][ACC_W:0]     sum;
    logic                           lock_s;

    assign lock_s = sync2_q;

    // One extra bit per channel captures the carry out of the accumulator.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_sum
        assign sum[g] = {1'b0, acc_q[g]} + {1'b0, INC[g*ACC_W +: ACC_W]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            acc_q       <= '0;
            ce_q        <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            sync1_q     <= pll_lock;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ce_q        <= ce_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Precedence: lock loss, then phase_sync, then normal accumulation.
    // Disabled channels keep their phase so re-enabling resumes the cadence.
    always_comb begin
        acc_d       = acc_q;
        ce_d        = '0;
        lock_lost_d = lock_lost_q;
        if (state_q != RUN) begin
            acc_d = '0;
        end else if (!lock_s) begin
            acc_d       = '0;
            lock_lost_d = 1'b1;
        end else if (phase_sync) begin
            acc_d = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_en[i]) begin
                    acc_d[i] = sum[i][ACC_W-1:0];
                    ce_d[i]  = sum[i][ACC_W];
                end
            end
        end
    end

    // sys_rst is decoded from the async-reset state flop, so it asserts
    // immediately on rst and releases only on a clock edge.
    always_comb begin
        sys_rst   = (state_q != RUN);
        ready     = (state_q == RUN);
        ce        = ce_q;
        lock_lost = lock_lost_q;
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// tb/tb_clock_enable_gen.sv - self-checking bench for clock_enable_gen

module tb_clock_enable_gen;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic [2:0] ch_en;
    logic       phase_sync;
    logic       sys_rst;
    logic       ready;
    logic [2:0] ce;
    logic       lock_lost;

    int n_pass;
    int n_total;

    typedef struct {
        logic [2:0] en;
        logic       ps;
        logic [2:0] ce;
    } vec_t;

    vec_t vecs[23];

    clock_enable_gen #(
        .NUM_CH      (3),
        .ACC_W       (4),
        .INC         ({4'd3, 4'd8, 4'd4}),
        .LOCK_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .ch_en      (ch_en),
        .phase_sync (phase_sync),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .ce         (ce),
        .lock_lost  (lock_lost)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lock already high: ready must rise exactly on the 11th edge
    // (2 sync + 1 WAIT_LOCK->COUNT + 8 counting).
    task automatic release_seq(input string tag, input logic exp_ll);
        for (int e = 1; e <= 10; e++) begin
            step();
            chk($sformatf("%s_hold_e%0d", tag, e), {ready, sys_rst, ce}, {1'b0, 1'b1, 3'b000});
        end
        step();
        chk($sformatf("%s_run", tag), {ready, sys_rst, ce, lock_lost}, {1'b1, 1'b0, 3'b000, exp_ll});
    endtask

    task automatic set_vec(input int i, input logic [2:0] en, input logic ps, input logic [2:0] c);
        vecs[i].en = en;
        vecs[i].ps = ps;
        vecs[i].ce = c;
    endtask

    initial begin
        logic [2:0] exp_ce;
        int         c2;

        n_pass  = 0;
        n_total = 0;

        // Channel 0: INC=4, channel 1: INC=8, channel 2: INC=3.
        // Entry accumulators are all zero.
        set_vec(0,  3'b111, 1'b0, 3'b000);
        set_vec(1,  3'b110, 1'b0, 3'b010);
        set_vec(2,  3'b110, 1'b0, 3'b000);
        set_vec(3,  3'b110, 1'b0, 3'b010);
        set_vec(4,  3'b111, 1'b0, 3'b000);
        set_vec(5,  3'b111, 1'b0, 3'b110);
        set_vec(6,  3'b111, 1'b0, 3'b001);
        set_vec(7,  3'b111, 1'b0, 3'b010);
        set_vec(8,  3'b111, 1'b0, 3'b000);
        set_vec(9,  3'b111, 1'b0, 3'b010);
        set_vec(10, 3'b111, 1'b1, 3'b000);
        set_vec(11, 3'b111, 1'b0, 3'b000);
        set_vec(12, 3'b111, 1'b0, 3'b010);
        set_vec(13, 3'b111, 1'b0, 3'b000);
        set_vec(14, 3'b111, 1'b0, 3'b011);
        set_vec(15, 3'b111, 1'b0, 3'b000);
        set_vec(16, 3'b111, 1'b0, 3'b110);
        set_vec(17, 3'b000, 1'b0, 3'b000);
        set_vec(18, 3'b000, 1'b1, 3'b000);
        set_vec(19, 3'b111, 1'b0, 3'b000);
        set_vec(20, 3'b111, 1'b0, 3'b010);
        set_vec(21, 3'b111, 1'b0, 3'b000);
        set_vec(22, 3'b111, 1'b0, 3'b011);

        rst        = 1'b1;
        pll_lock   = 1'b1;
        ch_en      = 3'b000;
        phase_sync = 1'b0;
        step();
        chk("reset_state", {sys_rst, ready, ce, lock_lost}, 6'b100000);
        rst = 1'b0;

        release_seq("release", 1'b0);

        // 48 run edges: ch0 every 4, ch1 every 2, ch2 at 6,11,16 (+16 period).
        ch_en = 3'b111;
        c2    = 0;
        for (int n = 1; n <= 48; n++) begin
            step();
            exp_ce[0] = (n % 4 == 0);
            exp_ce[1] = (n % 2 == 0);
            exp_ce[2] = (n inside {6, 11, 16, 22, 27, 32, 38, 43, 48});
            chk($sformatf("rate_n%0d", n), ce, exp_ce);
            if (ce[2]) c2++;
        end
        chk("frac_pulse_count", c2, 9);

        for (int i = 0; i < 23; i++) begin
            ch_en      = vecs[i].en;
            phase_sync = vecs[i].ps;
            step();
            chk($sformatf("vec%0d", i), ce, vecs[i].ce);
        end
        phase_sync = 1'b0;
        ch_en      = 3'b111;

        // Lock loss: two edges still run on the old synchronised value.
        pll_lock = 1'b0;
        step();
        chk("loss_e1", {ready, lock_lost, ce}, 5'b10000);
        step();
        chk("loss_e2", {ready, lock_lost, ce}, 5'b10110);
        step();
        chk("loss_e3", {sys_rst, ready, ce, lock_lost}, 6'b100001);

        // Relock with a one-cycle dropout during COUNT: count restarts,
        // so release moves from edge 11 to edge 18.
        pll_lock = 1'b1;
        for (int e = 1; e <= 6; e++) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        for (int e = 8; e <= 17; e++) begin
            step();
            if (e == 11 || e == 17) begin
                chk($sformatf("restart_hold_e%0d", e), {ready, sys_rst}, 2'b01);
            end
        end
        step();
        chk("restart_run", {ready, sys_rst, lock_lost}, 3'b101);
        for (int e = 1; e <= 4; e++) step();
        chk("relock_ce", {ce, lock_lost}, 4'b0111);

        // Async reset between edges, while ce is high.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {sys_rst, ready, ce, lock_lost}, 6'b100000);
        #1;
        rst = 1'b0;
        release_seq("rerelease", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
